// File: rtl/acc_ram_ctrl.sv
// ---------------------------------------------------------------------------
// acc_ram_ctrl
//   Sequencer/arbiter in front of the single-port accumulator SRAM.
//   - Accumulate requests from the MAC engine become read-add-write
//     sequences, or a single write when acc_first_i marks an overwrite.
//   - Host readout requests share the RAM port, arbitrated round-robin.
//   - clr_all_i launches a zero-fill sweep of all DEPTH words.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   acc_valid_i/_ready_o accumulate handshake; acc_addr_i word index,
//                        acc_data_i signed partial sum, acc_first_i overwrite
//   host_req_i/_gnt_o   host read handshake; host_addr_i word index
//   host_rvalid_o       one-cycle pulse with host_rdata_o valid
//   clr_all_i           start zero-fill sweep (pulse)
//   busy_o              FSM not idle or sweep pending
//   ovf_o / ovf_clr_i   sticky signed-overflow flag and its clear
//   ram_*               SRAM interface (ram_we_o: 1 = read, 0 = write)
// ---------------------------------------------------------------------------
module acc_ram_ctrl #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 24,
    parameter int DEPTH  = 2048
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     acc_valid_i,
    output logic                     acc_ready_o,
    input  logic [ADDR_W-3:0]        acc_addr_i,
    input  logic signed [DATA_W-1:0] acc_data_i,
    input  logic                     acc_first_i,
    input  logic                     host_req_i,
    input  logic [ADDR_W-3:0]        host_addr_i,
    output logic                     host_gnt_o,
    output logic                     host_rvalid_o,
    output logic signed [DATA_W-1:0] host_rdata_o,
    input  logic                     clr_all_i,
    output logic                     busy_o,
    output logic                     ovf_o,
    input  logic                     ovf_clr_i,
    output logic                     ram_en_o,
    output logic                     ram_we_o,
    output logic [ADDR_W-1:0]        ram_w_addr_o,
    output logic [ADDR_W-1:0]        ram_r_addr_o,
    output logic [31:0]              ram_wdata_o,
    input  logic signed [DATA_W-1:0] ram_rdata_i
);

    localparam int IDX_W = ADDR_W - 2;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        ADD,
        WR,
        HRD,
        HRSP,
        CLR
    } state_t;

    // Round-robin pointer: which requester wins when both ask.
    localparam logic RR_ACC  = 1'b0;
    localparam logic RR_HOST = 1'b1;

    state_t                     state_q, state_d;
    logic                       rr_q, rr_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic signed [DATA_W-1:0]   data_q, data_d;
    logic                       clr_pend_q, clr_pend_d;
    logic [IDX_W-1:0]           clr_cnt_q, clr_cnt_d;
    logic                       ovf_q, ovf_d;
    logic signed [DATA_W-1:0]   hrdata_q, hrdata_d;

    logic                       grant_acc;
    logic [IDX_W-1:0]           ram_idx;
    logic signed [DATA_W-1:0]   wdata;
    logic signed [DATA_W-1:0]   sum;

    // Two's-complement add, wrapping modulo 2^DATA_W.
    function automatic logic signed [DATA_W-1:0] wrap_add(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return a + b;
    endfunction

    // Signed overflow: operands share a sign that the result does not.
    function automatic logic add_ovf(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input logic signed [DATA_W-1:0] s
    );
        return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
    endfunction

    assign sum = wrap_add(ram_rdata_i, data_q);

    // Acc wins when it is alone or when the pointer favours it.
    assign grant_acc = acc_valid_i && (!host_req_i || rr_q == RR_ACC);

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        idx_d       = idx_q;
        data_d      = data_q;
        clr_pend_d  = clr_pend_q;
        clr_cnt_d   = clr_cnt_q;
        ovf_d       = ovf_q;
        hrdata_d    = hrdata_q;
        acc_ready_o = 1'b0;
        host_gnt_o  = 1'b0;
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b1;
        ram_idx     = idx_q;
        wdata       = data_q;

        // Clear first so that a set in ADD the same cycle takes priority.
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end

        // A sweep requested while an op is in flight waits for IDLE.
        if (clr_all_i && state_q != IDLE && state_q != CLR) begin
            clr_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (clr_all_i || clr_pend_q) begin
                    clr_pend_d = 1'b0;
                    clr_cnt_d  = '0;
                    state_d    = CLR;
                end else if (grant_acc) begin
                    acc_ready_o = 1'b1;
                    idx_d       = acc_addr_i;
                    data_d      = acc_data_i;
                    rr_d        = RR_HOST;
                    state_d     = acc_first_i ? WR : RD;
                end else if (host_req_i) begin
                    host_gnt_o = 1'b1;
                    idx_d      = host_addr_i;
                    rr_d       = RR_ACC;
                    state_d    = HRD;
                end
            end
            RD: begin
                ram_en_o = 1'b1;
                state_d  = ADD;
            end
            ADD: begin
                // Read data from RD is on ram_rdata_i this cycle.
                data_d = sum;
                if (add_ovf(ram_rdata_i, data_q, sum)) begin
                    ovf_d = 1'b1;
                end
                state_d = WR;
            end
            WR: begin
                ram_en_o = 1'b1;
                ram_we_o = 1'b0;
                state_d  = IDLE;
            end
            HRD: begin
                ram_en_o = 1'b1;
                state_d  = HRSP;
            end
            HRSP: begin
                hrdata_d = ram_rdata_i;
                state_d  = IDLE;
            end
            CLR: begin
                ram_en_o = 1'b1;
                ram_we_o = 1'b0;
                ram_idx  = clr_cnt_q;
                wdata    = '0;
                if (clr_all_i) begin
                    clr_cnt_d = '0;
                end else if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rr_q       <= RR_ACC;
            idx_q      <= '0;
            data_q     <= '0;
            clr_pend_q <= 1'b0;
            clr_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            hrdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            clr_pend_q <= clr_pend_d;
            clr_cnt_q  <= clr_cnt_d;
            ovf_q      <= ovf_d;
            hrdata_q   <= hrdata_d;
        end
    end

    // RAM controls decode straight from the state register, so an async
    // reset drops ram_en_o in the same cycle and no write can follow it.
    assign ram_w_addr_o = {ram_idx, 2'b00};
    assign ram_r_addr_o = {ram_idx, 2'b00};
    assign ram_wdata_o  = {{(32 - DATA_W){1'b0}}, wdata};

    // During HRSP the RAM output is forwarded so data and valid coincide;
    // afterwards the captured copy holds it until the next host read.
    assign host_rvalid_o = (state_q == HRSP);
    assign host_rdata_o  = (state_q == HRSP) ? ram_rdata_i : hrdata_q;

    assign busy_o = (state_q != IDLE) || clr_pend_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_acc_ram_ctrl.sv
module tb_acc_ram_ctrl;

    logic        clk;
    logic        rst;
    logic        acc_valid_i;
    logic        acc_ready_o;
    logic [10:0] acc_addr_i;
    logic signed [23:0] acc_data_i;
    logic        acc_first_i;
    logic        host_req_i;
    logic [10:0] host_addr_i;
    logic        host_gnt_o;
    logic        host_rvalid_o;
    logic signed [23:0] host_rdata_o;
    logic        clr_all_i;
    logic        busy_o;
    logic        ovf_o;
    logic        ovf_clr_i;
    logic        ram_en_o;
    logic        ram_we_o;
    logic [12:0] ram_w_addr_o;
    logic [12:0] ram_r_addr_o;
    logic [31:0] ram_wdata_o;
    logic signed [23:0] ram_rdata_i;

    int checks = 0;
    int errors = 0;

    acc_ram_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .acc_valid_i  (acc_valid_i),
        .acc_ready_o  (acc_ready_o),
        .acc_addr_i   (acc_addr_i),
        .acc_data_i   (acc_data_i),
        .acc_first_i  (acc_first_i),
        .host_req_i   (host_req_i),
        .host_addr_i  (host_addr_i),
        .host_gnt_o   (host_gnt_o),
        .host_rvalid_o(host_rvalid_o),
        .host_rdata_o (host_rdata_o),
        .clr_all_i    (clr_all_i),
        .busy_o       (busy_o),
        .ovf_o        (ovf_o),
        .ovf_clr_i    (ovf_clr_i),
        .ram_en_o     (ram_en_o),
        .ram_we_o     (ram_we_o),
        .ram_w_addr_o (ram_w_addr_o),
        .ram_r_addr_o (ram_r_addr_o),
        .ram_wdata_o  (ram_wdata_o),
        .ram_rdata_i  (ram_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural sync single-port SRAM with a write log.
    logic [23:0] mem [0:2047];
    int          wq_addr [$];
    logic [31:0] wq_data [$];

    always @(posedge clk) begin
        if (ram_en_o) begin
            if (!ram_we_o) begin
                mem[ram_w_addr_o[12:2]] <= ram_wdata_o[23:0];
                wq_addr.push_back(int'(ram_w_addr_o[12:2]));
                wq_data.push_back(ram_wdata_o);
            end else begin
                ram_rdata_i <= mem[ram_r_addr_o[12:2]];
            end
        end
    end

    task automatic do_acc(input logic [10:0] a, input logic [23:0] d, input logic f);
        int n;
        @(posedge clk); #1;
        acc_valid_i = 1'b1; acc_addr_i = a; acc_data_i = d; acc_first_i = f;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!acc_ready_o && n < 100);
        if (!acc_ready_o) begin
            errors++;
            $display("FAIL acc_accept_timeout addr=%0d got ready=%b want 1", a, acc_ready_o);
        end
        @(posedge clk); #1;
        acc_valid_i = 1'b0;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (busy_o && n < 100);
        if (busy_o) begin
            errors++;
            $display("FAIL acc_done_timeout addr=%0d busy=%b want 0", a, busy_o);
        end
    endtask

    task automatic host_read(input logic [10:0] a, output logic [23:0] d);
        int n;
        @(posedge clk); #1;
        host_req_i = 1'b1; host_addr_i = a;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!host_gnt_o && n < 100);
        if (!host_gnt_o) begin
            errors++;
            $display("FAIL host_gnt_timeout addr=%0d got gnt=0 want 1", a);
        end
        @(posedge clk); #1;
        host_req_i = 1'b0;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!host_rvalid_o && n < 100);
        d = host_rdata_o;
        @(negedge clk);
        checks++;
        if (host_rvalid_o !== 1'b0 || host_rdata_o !== d) begin
            errors++;
            $display("FAIL host_rvalid_pulse rvalid=%b rdata=%h want 0 and held %h", host_rvalid_o, host_rdata_o, d);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        acc_valid_i = 0; acc_addr_i = 0; acc_data_i = 0; acc_first_i = 0;
        host_req_i = 0; host_addr_i = 0; clr_all_i = 0; ovf_clr_i = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ram_en_o, ram_we_o, acc_ready_o, host_gnt_o, host_rvalid_o, busy_o, ovf_o} !== 7'b0100000) begin
            errors++;
            $display("FAIL reset_ctrl got en/we/rdy/gnt/rv/busy/ovf=%b%b%b%b%b%b%b want 0100000",
                     ram_en_o, ram_we_o, acc_ready_o, host_gnt_o, host_rvalid_o, busy_o, ovf_o);
        end
        checks++;
        if (ram_w_addr_o !== 13'd0 || ram_r_addr_o !== 13'd0 || ram_wdata_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_addr_data got w=%h r=%h wd=%h want 0", ram_w_addr_o, ram_r_addr_o, ram_wdata_o);
        end
        rst = 1'b1;
    endtask

    task automatic test_accumulate;
        logic [23:0] rd;
        do_acc(11'd5, 24'h000010, 1'b1);
        // Read-add-write with per-cycle checks.
        @(posedge clk); #1;
        acc_valid_i = 1'b1; acc_addr_i = 11'd5; acc_data_i = 24'h000020; acc_first_i = 1'b0;
        @(negedge clk);
        checks++;
        if (acc_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL acc_ready got %b want 1", acc_ready_o);
        end
        @(posedge clk); #1;
        acc_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_en_o !== 1'b1 || ram_we_o !== 1'b1 || ram_r_addr_o !== 13'd20) begin
            errors++;
            $display("FAIL rmw_rd got en=%b we=%b raddr=%0d want 1 1 20", ram_en_o, ram_we_o, ram_r_addr_o);
        end
        @(negedge clk);
        checks++;
        if (ram_en_o !== 1'b0) begin
            errors++;
            $display("FAIL rmw_add got en=%b want 0", ram_en_o);
        end
        @(negedge clk);
        checks++;
        if (ram_en_o !== 1'b1 || ram_we_o !== 1'b0 || ram_w_addr_o !== 13'd20 || ram_wdata_o !== 32'h00000030) begin
            errors++;
            $display("FAIL rmw_wr got en=%b we=%b waddr=%0d wdata=%h want 1 0 20 00000030",
                     ram_en_o, ram_we_o, ram_w_addr_o, ram_wdata_o);
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rmw_idle got busy=%b want 0", busy_o);
        end
        host_read(11'd5, rd);
        checks++;
        if (rd !== 24'h000030) begin
            errors++;
            $display("FAIL accum_readback got %h want 000030", rd);
        end
    endtask

    task automatic test_arbitration;
        string order;
        int    n;
        int    both;
        logic [23:0] rd;
        order = "";
        both = 0;
        @(posedge clk); #1;
        acc_valid_i = 1'b1; acc_addr_i = 11'd7; acc_data_i = 24'h000ABC; acc_first_i = 1'b1;
        host_req_i = 1'b1; host_addr_i = 11'd7;
        n = 0;
        while (order.len() < 4 && n < 200) begin
            @(negedge clk); n++;
            if (acc_ready_o && host_gnt_o) both++;
            if (acc_ready_o) order = {order, "A"};
            else if (host_gnt_o) order = {order, "H"};
            if (order.len() == 4) begin
                @(posedge clk); #1;
                acc_valid_i = 1'b0; host_req_i = 1'b0;
            end
        end
        checks++;
        if (order != "AHAH" || both != 0) begin
            errors++;
            $display("FAIL rr_order got %s both=%0d want AHAH both=0", order, both);
        end
        repeat (4) @(negedge clk);
        host_read(11'd7, rd);
        checks++;
        if (rd !== 24'h000ABC) begin
            errors++;
            $display("FAIL rr_readback got %h want 000abc", rd);
        end
    endtask

    task automatic test_overflow;
        logic [23:0] rd;
        do_acc(11'd9, 24'h7FFFFF, 1'b1);
        checks++;
        if (ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_before got %b want 0", ovf_o);
        end
        do_acc(11'd9, 24'h000001, 1'b0);
        checks++;
        if (ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got %b want 1", ovf_o);
        end
        host_read(11'd9, rd);
        checks++;
        if (rd !== 24'h800000) begin
            errors++;
            $display("FAIL ovf_wrap got %h want 800000", rd);
        end
        @(posedge clk); #1;
        ovf_clr_i = 1'b1;
        @(posedge clk); #1;
        ovf_clr_i = 1'b0;
        @(negedge clk);
        checks++;
        if (ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr got %b want 0", ovf_o);
        end
    endtask

    task automatic test_clear_all;
        int cyc;
        int viol;
        int bad;
        logic [23:0] rd;
        do_acc(11'd0, 24'h000111, 1'b1);
        do_acc(11'd1023, 24'h000222, 1'b1);
        do_acc(11'd2047, 24'h000333, 1'b1);
        wq_addr.delete(); wq_data.delete();
        @(posedge clk); #1;
        clr_all_i = 1'b1;
        acc_valid_i = 1'b1; acc_addr_i = 11'd4; acc_data_i = 24'h000055; acc_first_i = 1'b1;
        host_req_i = 1'b1; host_addr_i = 11'd4;
        viol = 0;
        @(negedge clk);
        if (acc_ready_o || host_gnt_o) viol++;
        @(posedge clk); #1;
        clr_all_i = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!busy_o || cyc >= 3000) break;
            cyc++;
            if (acc_ready_o || host_gnt_o) viol++;
        end
        acc_valid_i = 1'b0; host_req_i = 1'b0;
        checks++;
        if (cyc != 2048) begin
            errors++;
            $display("FAIL clr_busy_cycles got %0d want 2048", cyc);
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL clr_no_grants got %0d grants want 0", viol);
        end
        bad = 0;
        for (int i = 0; i < wq_addr.size(); i++) begin
            if (wq_addr[i] != i || wq_data[i] !== 32'd0) bad++;
        end
        checks++;
        if (wq_addr.size() != 2048 || bad != 0) begin
            errors++;
            $display("FAIL clr_writes got %0d writes %0d bad want 2048 writes 0 bad", wq_addr.size(), bad);
        end
        host_read(11'd0, rd);
        checks++;
        if (rd !== 24'd0) begin errors++; $display("FAIL clr_rd0 got %h want 000000", rd); end
        host_read(11'd1023, rd);
        checks++;
        if (rd !== 24'd0) begin errors++; $display("FAIL clr_rd1023 got %h want 000000", rd); end
        host_read(11'd2047, rd);
        checks++;
        if (rd !== 24'd0) begin errors++; $display("FAIL clr_rd2047 got %h want 000000", rd); end
    endtask

    task automatic test_clr_during_rmw;
        int n;
        logic [23:0] rd;
        do_acc(11'd100, 24'h000005, 1'b1);
        wq_addr.delete(); wq_data.delete();
        @(posedge clk); #1;
        acc_valid_i = 1'b1; acc_addr_i = 11'd100; acc_data_i = 24'h000003; acc_first_i = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        acc_valid_i = 1'b0;
        @(negedge clk);
        clr_all_i = 1'b1;
        @(posedge clk); #1;
        clr_all_i = 1'b0;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (busy_o && n < 3000);
        checks++;
        if (busy_o !== 1'b0 || wq_addr.size() != 2049) begin
            errors++;
            $display("FAIL clr_rmw_count got busy=%b writes=%0d want 0 2049", busy_o, wq_addr.size());
        end
        checks++;
        if (wq_addr.size() < 2 || wq_addr[0] != 100 || wq_data[0] !== 32'h00000008 || wq_addr[1] != 0) begin
            errors++;
            $display("FAIL clr_rmw_order got first writes %0d:%h want 100:00000008 then 0", wq_addr[0], wq_data[0]);
        end
        host_read(11'd100, rd);
        checks++;
        if (rd !== 24'd0) begin
            errors++;
            $display("FAIL clr_rmw_final got %h want 000000", rd);
        end
    endtask

    task automatic test_reset_mid_op;
        int n;
        logic [23:0] rd;
        @(posedge clk); #1;
        acc_valid_i = 1'b1; acc_addr_i = 11'd200; acc_data_i = 24'h000055; acc_first_i = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        acc_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ram_en_o !== 1'b1 || ram_we_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_in_wr got en=%b we=%b want 1 0", ram_en_o, ram_we_o);
        end
        n = wq_addr.size();
        rst = 1'b0;
        #1;
        checks++;
        if ({ram_en_o, ram_we_o, busy_o, acc_ready_o, host_gnt_o} !== 5'b01000 ||
            ram_w_addr_o !== 13'd0 || ram_wdata_o !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got en=%b we=%b busy=%b waddr=%0d wdata=%h want 0 1 0 0 0",
                     ram_en_o, ram_we_o, busy_o, ram_w_addr_o, ram_wdata_o);
        end
        @(posedge clk); #1;
        checks++;
        if (wq_addr.size() != n) begin
            errors++;
            $display("FAIL rst_mid_nowrite got %0d writes want %0d", wq_addr.size(), n);
        end
        @(negedge clk);
        rst = 1'b1;
        do_acc(11'd3, 24'h000123, 1'b1);
        host_read(11'd3, rd);
        checks++;
        if (rd !== 24'h000123) begin
            errors++;
            $display("FAIL rst_mid_recover got %h want 000123", rd);
        end
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_arbitration();
        test_overflow();
        test_clear_all();
        test_clr_during_rmw();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
